itof_pipe: RTL and testbench

ITOF_PIPE -- requirements
Module: itof_pipe

---
 rtl/itof_pipe.sv | 135 +++++++++++++
 tb/tb_itof_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/itof_pipe.sv
// itof_pipe: three-stage signed 32-bit integer to IEEE-754 binary32 converter.
// Stage 1 takes sign and magnitude, stage 2 normalises, stage 3 rounds
// (nearest, ties to even) and packs. All stages advance on one shared enable.
module itof_pipe (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x,
  input  logic        x_valid,
  output logic        x_ready,
  input  logic        flush,
  output logic [31:0] y,
  output logic        y_valid,
  input  logic        y_ready
);

  // Leading-zero count of a non-zero 32-bit magnitude (result unused for zero).
  function automatic logic [4:0] lzc32(input logic [31:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) begin
          found = 1'b1;
        end else begin
          n = n + 5'd1;
        end
      end
    end
    return n;
  endfunction

  logic        en_s;
  logic        xfer_s;

  logic        v1_q, v2_q, v3_q;
  logic        s1_sign_q, s1_zero_q;
  logic [31:0] s1_mag_q;
  logic        s2_sign_q, s2_zero_q;
  logic [31:0] s2_norm_q;
  logic [4:0]  s2_lzc_q;
  logic [31:0] y_q;

  logic [31:0] mag_d;
  logic [4:0]  lzc_d;
  logic [31:0] norm_d;
  logic        rnd_s;
  logic [23:0] man_sum_s;
  logic [7:0]  exp_s;
  logic [31:0] y_d;

  assign en_s    = !v3_q || y_ready;
  assign x_ready = en_s;
  assign xfer_s  = x_valid && en_s;
  assign y       = y_q;
  assign y_valid = v3_q;

  // Stage 1 magnitude; 0 - x of -2^31 wraps to 0x80000000, the correct unsigned |x|.
  always_comb begin
    mag_d = x;
    if (x[31]) begin
      mag_d = 32'd0 - x;
    end else begin
      mag_d = x;
    end
  end

  // Stage 2 normalisation: shift the leading one up to bit 31.
  always_comb begin
    lzc_d  = lzc32(s1_mag_q);
    norm_d = s1_mag_q << lzc_d;
  end

  // Stage 3 round-to-nearest-even on bits 7:0, exponent and pack.
  always_comb begin
    rnd_s     = s2_norm_q[7] & ((|s2_norm_q[6:0]) | s2_norm_q[8]);
    man_sum_s = {1'b0, s2_norm_q[30:8]} + {23'd0, rnd_s};
    // A carry out of the 23-bit field leaves it all-zero and bumps the exponent.
    exp_s     = 8'd158 - {3'd0, s2_lzc_q} + {7'd0, man_sum_s[23]};
    // A normalised non-zero magnitude always has bit 31 set, so either flag marks zero.
    if (s2_zero_q || !s2_norm_q[31]) begin
      y_d = 32'd0;
    end else begin
      y_d = {s2_sign_q, exp_s, man_sum_s[22:0]};
    end
  end

  // Stage valid bits: flush kills everything, otherwise shift on enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (flush) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (en_s) begin
      v1_q <= xfer_s;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end else begin
      v1_q <= v1_q;
      v2_q <= v2_q;
      v3_q <= v3_q;
    end
  end

  // Stage data registers advance together with the valids and hold on stall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_sign_q <= 1'b0;
      s1_zero_q <= 1'b0;
      s1_mag_q  <= 32'd0;
      s2_sign_q <= 1'b0;
      s2_zero_q <= 1'b0;
      s2_norm_q <= 32'd0;
      s2_lzc_q  <= 5'd0;
      y_q       <= 32'd0;
    end else if (en_s) begin
      s1_sign_q <= x[31];
      s1_zero_q <= (x == 32'd0);
      s1_mag_q  <= mag_d;
      s2_sign_q <= s1_sign_q;
      s2_zero_q <= s1_zero_q;
      s2_norm_q <= norm_d;
      s2_lzc_q  <= lzc_d;
      y_q       <= y_d;
    end else begin
      y_q       <= y_q;
    end
  end

endmodule

// File: tb/tb_itof_pipe.sv
// Self-checking bench for itof_pipe: scoreboard of expected results filled
// when operands are accepted, matched against results the consumer takes.
module tb_itof_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] x;
  logic        x_valid;
  logic        x_ready;
  logic        flush;
  logic [31:0] y;
  logic        y_valid;
  logic        y_ready;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          timeouts = 0;
  int          cyc      = 0;

  logic [31:0] exp_y[$];
  int          acc_c[$];
  logic [31:0] obs_y[$];
  int          obs_c[$];

  itof_pipe dut (
    .clk(clk), .rstn(rstn), .x(x), .x_valid(x_valid), .x_ready(x_ready),
    .flush(flush), .y(y), .y_valid(y_valid), .y_ready(y_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every result the consumer takes, with the cycle it was offered.
  always @(negedge clk) begin
    if (rstn && y_valid && y_ready) begin
      obs_y.push_back(y);
      obs_c.push_back(cyc);
    end
  end

  // Reference conversion: exact integer arithmetic with explicit remainder rounding.
  function automatic logic [31:0] ref_cvt(input logic [31:0] v);
    logic        s;
    logic [63:0] a, q, r, half;
    logic [7:0]  e;
    int          p, k;
    if (v == 32'd0) return 32'd0;
    s = v[31];
    a = s ? (64'd0 - {{32{v[31]}}, v}) : {32'd0, v};
    p = 0;
    for (int i = 0; i < 64; i++) if (a[i]) p = i;
    e = 8'(127 + p);
    if (p <= 23) begin
      q = a << (23 - p);
    end else begin
      k = p - 23;
      q = a >> k;
      r = a - (q << k);
      half = 64'd1 << (k - 1);
      if (r > half || (r == half && q[0])) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e = e + 8'd1;
      end
    end
    return {s, e, q[22:0]};
  endfunction

  // Offer one operand (called just after a rising edge); returns one cycle after acceptance.
  task automatic send(input logic [31:0] v, input logic [31:0] e, input bit keep);
    bit ok;
    ok = 1'b0;
    x = v;
    x_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (x_ready) begin
        ok = 1'b1;
        if (keep) begin
          exp_y.push_back(e);
          acc_c.push_back(cyc);
        end
      end
      @(posedge clk); #1;
    end
    if (!ok) timeouts++;
  endtask

  task automatic idle(input int n);
    x_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_obs(input int n);
    int t;
    t = 0;
    x_valid = 1'b0;
    while (obs_y.size() < n && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    if (obs_y.size() < n) timeouts++;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0; x = 32'd0; x_valid = 1'b0; flush = 1'b0; y_ready = 1'b1;
    #1;
    n_checks++;
    if (y !== 32'd0 || y_valid !== 1'b0 || x_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: y=%h y_valid=%b x_ready=%b, required 00000000/0/1", y, y_valid, x_ready);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (y !== 32'd0 || y_valid !== 1'b0 || x_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL after_reset: y=%h y_valid=%b x_ready=%b, required 00000000/0/1", y, y_valid, x_ready);
    end
  endtask

  task automatic test_stream;
    logic [31:0] e, o;
    int a, c;
    send(32'd1,         32'h3F800000, 1'b1);
    send(32'hFFFFFFFF,  32'hBF800000, 1'b1);
    send(32'd0,         32'h00000000, 1'b1);
    send(32'h7FFFFFFF,  32'h4F000000, 1'b1);
    wait_obs(4);
    while (exp_y.size() > 0 && obs_y.size() > 0) begin
      e = exp_y.pop_front(); o = obs_y.pop_front();
      a = acc_c.pop_front(); c = obs_c.pop_front();
      n_checks++;
      if (o !== e || c - a != 3) begin
        n_fail++;
        $display("FAIL stream: y=%h latency=%0d, required %h latency 3", o, c - a, e);
      end
    end
    n_checks++;
    if (exp_y.size() != 0 || obs_y.size() != 0 || timeouts != 0) begin
      n_fail++;
      $display("FAIL stream_count: left exp=%0d obs=%0d timeouts=%0d, required 0/0/0", exp_y.size(), obs_y.size(), timeouts);
    end
    exp_y.delete(); obs_y.delete(); acc_c.delete(); obs_c.delete(); timeouts = 0;
  endtask

  task automatic test_ties;
    logic [31:0] e, o;
    send(32'd16777217,  32'h4B800000, 1'b1);
    send(32'd16777219,  32'h4B800002, 1'b1);
    send(32'h80000000,  32'hCF000000, 1'b1);
    send(32'd16777216,  32'h4B800000, 1'b1);
    send(32'd16777215,  32'h4B7FFFFF, 1'b1);
    send(32'hFF000000,  32'hCB800000, 1'b1);
    send(32'd16777221,  ref_cvt(32'd16777221), 1'b1);
    send(32'h7FFFFFBF,  ref_cvt(32'h7FFFFFBF), 1'b1);
    wait_obs(8);
    while (exp_y.size() > 0 && obs_y.size() > 0) begin
      e = exp_y.pop_front(); o = obs_y.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL ties: y=%h, required %h", o, e);
      end
    end
    n_checks++;
    if (exp_y.size() != 0 || obs_y.size() != 0 || timeouts != 0) begin
      n_fail++;
      $display("FAIL ties_count: left exp=%0d obs=%0d timeouts=%0d, required 0/0/0", exp_y.size(), obs_y.size(), timeouts);
    end
    exp_y.delete(); obs_y.delete(); acc_c.delete(); obs_c.delete(); timeouts = 0;
  endtask

  task automatic test_backpressure;
    logic [31:0] e, o, held;
    send(32'd3,         ref_cvt(32'd3), 1'b1);
    send(32'hFFFFFF85,  ref_cvt(32'hFFFFFF85), 1'b1);
    send(32'd123456789, ref_cvt(32'd123456789), 1'b1);
    send(32'd1000,      ref_cvt(32'd1000), 1'b1);
    x_valid = 1'b0;
    y_ready = 1'b0;
    held = y;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (y_valid !== 1'b1 || y !== held || x_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall: y=%h y_valid=%b x_ready=%b, required %h/1/0", y, y_valid, x_ready, held);
      end
      @(posedge clk); #1;
    end
    y_ready = 1'b1;
    wait_obs(4);
    while (exp_y.size() > 0 && obs_y.size() > 0) begin
      e = exp_y.pop_front(); o = obs_y.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL backpressure: y=%h, required %h", o, e);
      end
    end
    n_checks++;
    if (exp_y.size() != 0 || obs_y.size() != 0 || timeouts != 0) begin
      n_fail++;
      $display("FAIL bp_count: left exp=%0d obs=%0d timeouts=%0d, required 0/0/0", exp_y.size(), obs_y.size(), timeouts);
    end
    exp_y.delete(); obs_y.delete(); acc_c.delete(); obs_c.delete(); timeouts = 0;
  endtask

  task automatic test_flush;
    logic [31:0] e, o;
    int a, c;
    send(32'd5, ref_cvt(32'd5), 1'b0);
    send(32'd6, ref_cvt(32'd6), 1'b0);
    flush = 1'b1;
    send(32'd7, ref_cvt(32'd7), 1'b0);
    flush = 1'b0;
    n_checks++;
    if (y_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_kill: y_valid=%b, required 0", y_valid);
    end
    send(32'hFFFFFFF7, 32'hC1100000, 1'b1);
    wait_obs(1);
    while (exp_y.size() > 0 && obs_y.size() > 0) begin
      e = exp_y.pop_front(); o = obs_y.pop_front();
      a = acc_c.pop_front(); c = obs_c.pop_front();
      n_checks++;
      if (o !== e || c - a != 3) begin
        n_fail++;
        $display("FAIL flush_after: y=%h latency=%0d, required %h latency 3", o, c - a, e);
      end
    end
    n_checks++;
    if (exp_y.size() != 0 || obs_y.size() != 0 || timeouts != 0) begin
      n_fail++;
      $display("FAIL flush_count: left exp=%0d obs=%0d timeouts=%0d, required 0/0/0", exp_y.size(), obs_y.size(), timeouts);
    end
    exp_y.delete(); obs_y.delete(); acc_c.delete(); obs_c.delete(); timeouts = 0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] e, o;
    int a, c;
    send(32'd11, 32'd0, 1'b0);
    send(32'd12, 32'd0, 1'b0);
    send(32'd13, 32'd0, 1'b0);
    x_valid = 1'b0;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (y !== 32'd0 || y_valid !== 1'b0 || x_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: y=%h y_valid=%b x_ready=%b, required 00000000/0/1", y, y_valid, x_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    idle(6);
    n_checks++;
    if (obs_y.size() != 0) begin
      n_fail++;
      $display("FAIL reset_stale: results seen=%0d, required 0", obs_y.size());
    end
    obs_y.delete(); obs_c.delete();
    send(32'd2, 32'h40000000, 1'b1);
    wait_obs(1);
    while (exp_y.size() > 0 && obs_y.size() > 0) begin
      e = exp_y.pop_front(); o = obs_y.pop_front();
      a = acc_c.pop_front(); c = obs_c.pop_front();
      n_checks++;
      if (o !== e || c - a != 3) begin
        n_fail++;
        $display("FAIL reset_first: y=%h latency=%0d, required %h latency 3", o, c - a, e);
      end
    end
    n_checks++;
    if (exp_y.size() != 0 || obs_y.size() != 0 || timeouts != 0) begin
      n_fail++;
      $display("FAIL reset_count: left exp=%0d obs=%0d timeouts=%0d, required 0/0/0", exp_y.size(), obs_y.size(), timeouts);
    end
    exp_y.delete(); obs_y.delete(); acc_c.delete(); obs_c.delete(); timeouts = 0;
  endtask

  task automatic test_random;
    logic [31:0] e, o, v;
    int mode;
    for (int i = 0; i < 3000; i++) begin
      mode = int'($urandom_range(0, 7));
      case (mode)
        0: v = 32'd0;
        1: v = 32'h80000000;
        2: v = 32'(int'($urandom_range(0, 33554432)) - 16777216);
        3: v = 32'h7FFFFFFF - 32'($urandom_range(0, 255));
        default: v = $urandom;
      endcase
      x = v;
      x_valid = ($urandom_range(0, 3) != 0);
      y_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (x_valid && x_ready) exp_y.push_back(ref_cvt(v));
      @(posedge clk); #1;
    end
    x_valid = 1'b0;
    y_ready = 1'b1;
    wait_obs(exp_y.size());
    while (exp_y.size() > 0 && obs_y.size() > 0) begin
      e = exp_y.pop_front(); o = obs_y.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL random: y=%h, required %h", o, e);
      end
    end
    n_checks++;
    if (exp_y.size() != 0 || obs_y.size() != 0 || timeouts != 0) begin
      n_fail++;
      $display("FAIL random_count: left exp=%0d obs=%0d timeouts=%0d, required 0/0/0", exp_y.size(), obs_y.size(), timeouts);
    end
    exp_y.delete(); obs_y.delete(); acc_c.delete(); obs_c.delete(); timeouts = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_ties();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
